// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-enabled data memory.
// Geometry helpers and the address-to-word-index mapping.
package dm_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_w_of(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic logic [31:0] word_idx(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          off_w
  );
    return (addr - base) >> off_w;
  endfunction

  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          off_w,
    input int          depth
  );
    logic [31:0] idx;
    idx = word_idx(addr, base, off_w);
    return (addr >= base) && (idx < 32'(depth));
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational lane merge: byte k of the result comes from wdata
// when byteen[k] is set, otherwise from the old word.
module dm_byte_merge
  import dm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          old_word,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [bytes_of(DATA_W)-1:0] byteen,
  output logic [DATA_W-1:0]          merged
);

  // replace only the enabled byte lanes
  always_comb begin
    merged = old_word;
    for (int k = 0; k < bytes_of(DATA_W); k++) begin
      if (byteen[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/dm_byteen_ram.sv
// Byte-enabled data memory with clear sweep and pipelined reads.
// Optional write trace outputs under DM_WR_TRACE_EN.
module dm_byteen_ram
  import dm_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 m_data_addr,
  input  logic [DATA_W-1:0]           m_data_wdata,
  input  logic [bytes_of(DATA_W)-1:0] m_data_byteen,
  input  logic                        m_data_rd,
  input  logic [31:0]                 m_inst_addr,
  output logic [DATA_W-1:0]           m_data_rdata,
  output logic                        m_data_rvalid,
  output logic                        ready,
  output logic                        err_range
`ifdef DM_WR_TRACE_EN
  ,
  output logic                        trace_valid,
  output logic [31:0]                 trace_pc,
  output logic [31:0]                 trace_addr,
  output logic [DATA_W-1:0]           trace_data
`endif
);

  localparam int OFF_W = off_w_of(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  logic [IDX_W-1:0]   clr_idx;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               hit;
  logic [IDX_W-1:0]   idx;
  logic               act;
  logic               rd_ok;
  logic               wr_ok;
  logic               any_req;
  logic [DATA_W-1:0]  old_w;
  logic [DATA_W-1:0]  merged;
  logic [DATA_W-1:0]  rd_word;

  logic [RD_LAT-1:0]  v_q;
  logic [DATA_W-1:0]  d_q [RD_LAT];

  assign act     = reset && (state == READY);
  assign hit     = in_range(m_data_addr, BASE_ADDR, OFF_W, DEPTH);
  assign idx     = IDX_W'(word_idx(m_data_addr, BASE_ADDR, OFF_W));
  assign any_req = m_data_rd || (|m_data_byteen);
  assign rd_ok   = act && m_data_rd;
  assign wr_ok   = act && (|m_data_byteen) && hit;
  assign old_w   = mem[idx];
  assign rd_word = hit ? old_w : '0;

  dm_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_word (old_w),
    .wdata    (m_data_wdata),
    .byteen   (m_data_byteen),
    .merged   (merged)
  );

  // storage: clear sweep first, then merged writes
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      else if (wr_ok)     mem[idx]     <= merged;
    end
  end

  // sweep sequencing, ready and sticky range error
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      ready     <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == IDX_W'(DEPTH - 1)) begin
          state <= READY;
          ready <= 1'b1;
        end
      end
      if (act && any_req && !hit) err_range <= 1'b1;
    end
  end

  // read pipeline; data stages only load with a valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= rd_ok;
      if (rd_ok) d_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign m_data_rvalid = v_q[RD_LAT-1];
  assign m_data_rdata  = d_q[RD_LAT-1];

`ifdef DM_WR_TRACE_EN
  // one-cycle trace of each accepted write
  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= wr_ok;
      if (wr_ok) begin
        trace_pc   <= m_inst_addr;
        trace_addr <= {m_data_addr[31:OFF_W], {OFF_W{1'b0}}};
        trace_data <= merged;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^m_inst_addr;
`endif

endmodule

// File: tb/tb_dm_byteen_ram.sv
// Directed bench for dm_byteen_ram, RD_LAT=1 and RD_LAT=2 side by side.
// Define DM_WR_TRACE_EN to also check the write trace outputs.
module tb_dm_byteen_ram;

  localparam int DW = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          rd;
  logic [31:0]   pc;

  logic [DW-1:0] rdata1, rdata2;
  logic          rv1, rv2;
  logic          rdy1, rdy2;
  logic          err1, err2;
`ifdef DM_WR_TRACE_EN
  logic          tv1, tv2;
  logic [31:0]   tpc1, tpc2, tad1, tad2;
  logic [DW-1:0] tdt1, tdt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_byteen_ram #(
    .DATA_W (DW), .DEPTH (DP),
    .BASE_ADDR (32'h0), .RD_LAT (1)
  ) u_dut1 (
    .clk (clk), .reset (reset),
    .m_data_addr (addr), .m_data_wdata (wdata),
    .m_data_byteen (be), .m_data_rd (rd),
    .m_inst_addr (pc),
    .m_data_rdata (rdata1), .m_data_rvalid (rv1),
    .ready (rdy1), .err_range (err1)
`ifdef DM_WR_TRACE_EN
    ,
    .trace_valid (tv1), .trace_pc (tpc1),
    .trace_addr (tad1), .trace_data (tdt1)
`endif
  );

  dm_byteen_ram #(
    .DATA_W (DW), .DEPTH (DP),
    .BASE_ADDR (32'h0), .RD_LAT (2)
  ) u_dut2 (
    .clk (clk), .reset (reset),
    .m_data_addr (addr), .m_data_wdata (wdata),
    .m_data_byteen (be), .m_data_rd (rd),
    .m_inst_addr (pc),
    .m_data_rdata (rdata2), .m_data_rvalid (rv2),
    .ready (rdy2), .err_range (err2)
`ifdef DM_WR_TRACE_EN
    ,
    .trace_valid (tv2), .trace_pc (tpc2),
    .trace_addr (tad2), .trace_data (tdt2)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  b
  );
    addr  = a;
    wdata = d;
    be    = b;
    tick();
    be = 4'h0;
  endtask

  task automatic rd_both(
    input logic [31:0] a,
    input logic [31:0] exp
  );
    addr = a;
    rd   = 1'b1;
    tick();
    rd = 1'b0;
    check("rv1_at_lat1", 64'(rv1), 64'd1);
    check("rd1_data", 64'(rdata1), 64'(exp));
    check("rv2_early", 64'(rv2), 64'd0);
    tick();
    check("rv1_pulse_end", 64'(rv1), 64'd0);
    check("rv2_at_lat2", 64'(rv2), 64'd1);
    check("rd2_data", 64'(rdata2), 64'(exp));
  endtask

  initial begin
    int cnt;
    logic bad;

    reset = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    rd    = 1'b0;
    pc    = '0;
    tick();
    tick();
    check("rst_ready", 64'({rdy1, rdy2}), 64'd0);
    check("rst_rvalid", 64'({rv1, rv2}), 64'd0);
    check("rst_rdata1", 64'(rdata1), 64'd0);
    check("rst_rdata2", 64'(rdata2), 64'd0);
    check("rst_err", 64'({err1, err2}), 64'd0);

    // requests during the sweep must be dropped
    addr  = 32'h0;
    wdata = 32'hFFFF_FFFF;
    be    = 4'hF;
    rd    = 1'b1;
    reset = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rv1 || rv2 || rdy1 || err1) bad = 1'b1;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cnt = 0;
    while (!rdy1 && cnt < 100) begin
      tick();
      cnt++;
      if (rv1 || rv2 || err1 || err2) bad = 1'b1;
    end
    be = 4'h0;
    rd = 1'b0;
    check("clear_cycles", 64'(cnt), 64'(DP));
    check("ready2", 64'(rdy2), 64'd1);
    check("clear_quiet", 64'(bad), 64'd0);
    check("err_after_clr", 64'({err1, err2}), 64'd0);

    rd_both(32'h0, 32'h0);
    rd_both(32'h3C, 32'h0);

    pc = 32'h3000;
    wr(32'h4, 32'hAABB_CCDD, 4'hF);
    pc = 32'h3010;
    wr(32'h4, 32'h0000_1100, 4'b0010);
`ifdef DM_WR_TRACE_EN
    check("trace_valid", 64'(tv1), 64'd1);
    check("trace_pc", 64'(tpc1), 64'h3010);
    check("trace_addr", 64'(tad1), 64'h4);
    check("trace_data", 64'(tdt1), 64'hAABB_11DD);
`endif
    rd_both(32'h4, 32'hAABB_11DD);
    rd_both(32'h7, 32'hAABB_11DD);

    // read-first then write-visible
    addr  = 32'h8;
    wdata = 32'h1234_5678;
    be    = 4'hF;
    rd    = 1'b1;
    tick();
    be = 4'h0;
    check("rf_rv1", 64'(rv1), 64'd1);
    check("rf_rd1_old", 64'(rdata1), 64'h0);
    tick();
    rd = 1'b0;
    check("rf_rd1_new", 64'(rdata1), 64'h1234_5678);
    check("rf_rv2", 64'(rv2), 64'd1);
    check("rf_rd2_old", 64'(rdata2), 64'h0);
    tick();
    check("rf_rd2_new", 64'(rdata2), 64'h1234_5678);
    check("rf_rv1_low", 64'(rv1), 64'd0);
    tick();
    check("hold_rv1", 64'(rv1), 64'd0);
    check("hold_rd1", 64'(rdata1), 64'h1234_5678);

    // out-of-range accesses
    check("err_pre", 64'(err1), 64'd0);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    check("err_set1", 64'(err1), 64'd1);
    check("err_set2", 64'(err2), 64'd1);
    tick();
    tick();
    check("err_held", 64'(err1), 64'd1);
    rd_both(32'h0, 32'h0);
    rd_both(32'h4, 32'hAABB_11DD);
    rd_both(32'h40, 32'h0);
    check("err_still", 64'({err1, err2}), 64'b11);

    // reset cancels an in-flight read
    addr = 32'h4;
    rd   = 1'b1;
    tick();
    rd    = 1'b0;
    reset = 1'b0;
    tick();
    check("rstrd_rv2", 64'(rv2), 64'd0);
    check("rstrd_rd2", 64'(rdata2), 64'd0);
    check("rstrd_rdy", 64'({rdy1, rdy2}), 64'd0);
    check("rstrd_err", 64'({err1, err2}), 64'd0);
    tick();
    check("rstrd_rv2_b", 64'(rv2), 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_byteen_ram.md
Name: dm_byteen_ram

Overview:
- Parametrised data-memory block for the pipelined MIPS core's data-side bus (m_data_* interface).
- Successor to the flat bench-only data array:
  - configurable data width, depth and base address
  - registered read path with 1- or 2-cycle latency
  - hardware clear sweep after reset
  - sticky out-of-range error flag
- Sits between the core's MEM stage and the system bus; synthesizable.

Parameters:
- DATA_W, 32, word width in bits; 32 or 64.
- DEPTH, 4096, number of words; power of two, ≥ 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DATA_W/8.
- RD_LAT, 1, read latency in cycles; 1 or 2.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low; asserted when 0.
- m_data_addr  in  32  byte address; low log2(DATA_W/8) bits ignored (aligned down).
- m_data_wdata  in  DATA_W  write data, lane-aligned.
- m_data_byteen  in  DATA_W/8  per-byte write enable; any bit set = write.
- m_data_rd  in  1  read request.
- m_inst_addr  in  32  PC of the issuing instruction (trace only).
- m_data_rdata  out  DATA_W  read data.
- m_data_rvalid  out  1  one-cycle pulse: m_data_rdata is valid.
- ready  out  1  high when requests are accepted.
- err_range  out  1  sticky: an out-of-range access occurred.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=CLEAR, clr_idx=0.
  - ready=0, m_data_rvalid=0, m_data_rdata=0, err_range=0.
  - Read pipeline flushed.
- State CLEAR:
  - Each cycle writes zero to word clr_idx, then clr_idx++.
  - After clr_idx==DEPTH-1 is written, next state is READY; ready=1 from that cycle on.
  - Clear takes exactly DEPTH cycles after reset releases.
  - Requests during CLEAR are dropped silently: no write, no rvalid, no error.
  - Reset asserted mid-CLEAR restarts the sweep at 0.
- State READY (stays until reset):
  - Index: idx = (m_data_addr - BASE_ADDR) >> log2(DATA_W/8).
  - In-range means m_data_addr ≥ BASE_ADDR and idx < DEPTH.
- Write (|m_data_byteen, in range):
  - At the edge: mem[idx] = merge(old, m_data_wdata, m_data_byteen); lane k replaced iff byteen[k].
  - Unselected bytes are preserved.
- Read (m_data_rd, in range):
  - m_data_rdata = mem[idx] sampled at the request edge.
  - m_data_rvalid pulses RD_LAT cycles after the request.
  - One read may be issued every cycle (fully pipelined).
- Read and write to the same word in one cycle: read returns pre-write data (read-first).
- Write at cycle t, read at t+1 to the same word: returns the written data.
- Out of range (read or write):
  - Access dropped; err_range set at the next edge and held until reset.
  - A read still produces an rvalid pulse after RD_LAT with rdata=0.
- m_data_rdata holds its last value when rvalid is low.
- Reset mid-read: pending rvalid is cancelled.

Optional Feature:
- Macro DM_WR_TRACE_EN.
- Defined:
  - Adds outputs trace_valid (1), trace_pc (32), trace_addr (32), trace_data (DATA_W).
  - trace_valid pulses the cycle after each accepted write, carrying m_inst_addr, the aligned byte address and the full merged word.
  - Zero in reset and CLEAR.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package dm_pkg:
  - state enum {CLEAR, READY}
  - BYTES = DATA_W/8 and OFF_W = log2(BYTES) helpers
  - function for in-range index calculation
- Sub-module dm_byte_merge: combinational lane merge of old word, wdata and byteen. Reused by the write path and by trace.

Test Plan:
- Release reset, DEPTH=16 -> ready rises exactly 16 cycles later; reading any word returns 0; err_range=0.
- Write addr 0x4, wdata 0xAABBCCDD, byteen 4'b1111; then byteen 4'b0010, wdata 0x0000_1100 -> read 0x4 returns 0xAABB11DD; rvalid exactly RD_LAT cycles after the request (test RD_LAT=1 and RD_LAT=2).
- Same cycle: write 0x12345678 to 0x8 (holding 0) and read 0x8 -> rdata 0; a read in the next cycle -> 0x12345678.
- Write to addr 0x0000_4000 with DEPTH=4096, BASE_ADDR=0 -> no memory change; err_range=1 next cycle and held; an out-of-range read -> rvalid with rdata 0.
- Unaligned addr 0x7 read after a write to 0x4 -> same word returned.
- Reset at clear step 5 -> sweep restarts; ready only after a full DEPTH cycles; with DM_WR_TRACE_EN, a write at PC 0x3010 -> trace_valid=1, trace_pc=0x3010, merged data.
